dht11_frame_receiver: RTL
=========================

// Module: dht11_frame_receiver
// PURPOSE
//  Consumes the DHT11 single-wire line after the start stage releases it.
//  Sits directly downstream of the start stage: it is armed by that stage's confirm pulse.
//  Decodes the sensor response and the 40-bit frame (RH int, RH dec, T int, T dec, checksum).
//  Publishes the checksum-verified bytes to the rest of the design.
//  Runs on the 1 MHz divided clock, so 1 clk = 1 us.
// PARAMETERS
//  BIT_THRESH   48   high-phase cycles; a bit whose high phase is > BIT_THRESH decodes as '1', otherwise '0'
//  TIMEOUT      200  max cycles allowed in any waiting/measuring state before abort
//  CNT_W        8    phase counter width; must hold TIMEOUT
// PORTS
//  clk           in   1  divided system clock (1 MHz)
//  rst           in   1  synchronous, active-low reset (0 = reset)
//  start         in   1  1-cycle arm pulse from start stage (line released by host)
//  dht_in        in   1  raw DHT11 line level (asynchronous to clk)
//  busy          out  1  high from accepted start until DONE/ERROR exit
//  hum_int       out  8  humidity integer byte (last good frame)
//  hum_dec       out  8  humidity decimal byte
//  temp_int      out  8  temperature integer byte
//  temp_dec      out  8  temperature decimal byte
//  data_valid    out  1  1-cycle pulse: new good frame on outputs
//  checksum_err  out  1  1-cycle pulse: frame received, checksum mismatch
//  timeout_err   out  1  1-cycle pulse: phase exceeded TIMEOUT
// BEHAVIOUR
//  Reset (rst==0 at posedge): state IDLE, all outputs 0, shift reg/counters 0; applies mid-frame too.
//  dht_in passes a 2-FF synchronizer, so edge detection lags the pin by 2 clk.
//   rise/fall are derived from the synced level vs its previous value.
//  Phase counter cnt: cleared on every state change; otherwise increments, saturating at all-ones.
//  Timeout: in any state except IDLE/CHECK, if cnt reaches TIMEOUT:
//   -> pulse timeout_err, go IDLE, data outputs hold.
//  FSM:
//   IDLE:      busy=0; start=1 -> WAIT_LOW (busy=1 next cycle).
//              start while busy is ignored (no restart, no error).
//   WAIT_LOW:  fall -> RESP_LOW   (sensor ack, nominal 20-40 us after release)
//   RESP_LOW:  rise -> RESP_HIGH  (nominal 80 us low)
//   RESP_HIGH: fall -> BIT_LOW, bit_idx=0   (nominal 80 us high)
//   BIT_LOW:   rise -> BIT_HIGH   (nominal 50 us low)
//   BIT_HIGH:  fall -> shift {sr[38:0], cnt>BIT_THRESH} into 40-bit sr, MSB first.
//              if bit_idx==39 -> CHECK, else bit_idx++ and -> BIT_LOW.
//   CHECK (1 cycle): sum = (sr[39:32]+sr[31:24]+sr[23:16]+sr[15:8]) mod 256.
//              sum==sr[7:0] -> load hum_int,hum_dec,temp_int,temp_dec from sr[39:8], pulse data_valid.
//              else -> pulse checksum_err, data outputs hold previous values.
//              both -> IDLE, busy=0 same cycle as pulse.
//  cnt at the BIT_HIGH falling edge = high width in us (+-1); the 2-FF lag is common to both edges and cancels.
//  Trailing sensor 50 us low after bit 39 is ignored: IDLE does not react to the line.
//  Pulses are exactly 1 cycle; data_valid/checksum_err/timeout_err are mutually exclusive.
// TESTING
//  1. Good frame 0x37,0x00,0x19,0x00,0x50 with nominal timings
//     -> hum_int=55, temp_int=25, one data_valid pulse, busy falls.
//  2. Same frame with checksum 0x51
//     -> one checksum_err pulse, outputs keep prior values (0 after reset).
//  3. start, line held high 250 us -> timeout_err once at cnt=200 in WAIT_LOW, busy=0, no data_valid.
//  4. Bit threshold: high phases of 48 us and 49 us -> decoded '0' and '1' respectively.
//  5. Second start pulse during bit 10 -> ignored, frame completes normally with data_valid.
//  6. rst=0 for one cycle during bit 20 -> IDLE, all outputs 0.
//     Next start + good frame decodes correctly.

Source files
------------

// File: rtl/dht11_frame_receiver.sv
// DHT11 frame receiver: decodes the sensor response and the 40-bit frame,
// then publishes the checksum-verified bytes. Runs at 1 clk = 1 us.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line ignored, waiting for the start-stage arm pulse
// WAIT_LOW  | line released, waiting for the sensor to pull it low (ack)
// RESP_LOW  | sensor response low phase (~80 us)
// RESP_HIGH | sensor response high phase (~80 us)
// BIT_LOW   | low preamble of a data bit (~50 us)
// BIT_HIGH  | high phase of a data bit; its width encodes the bit value
// CHECK     | one cycle: verify checksum, publish or flag the frame
module dht11_frame_receiver #(
  parameter int BIT_THRESH = 48,
  parameter int TIMEOUT    = 200,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dht_in,
  output logic       busy,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       data_valid,
  output logic       checksum_err,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOW  = 3'd1,
    RESP_LOW  = 3'd2,
    RESP_HIGH = 3'd3,
    BIT_LOW   = 3'd4,
    BIT_HIGH  = 3'd5,
    CHECK     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   THRESH_C  = (CNT_W+1)'(BIT_THRESH);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [39:0]      sr;
  logic [5:0]       bit_idx;
  logic             dht_s1;
  logic             dht_s2;
  logic             dht_prev;

  logic             rise;
  logic             fall;
  logic             timed_out;
  logic [CNT_W:0]   high_width;
  logic             bit_val;
  logic [7:0]       sum;

  logic             do_shift;
  logic             do_load;
  logic             do_cerr;
  logic             do_tout;
  logic             bit_clr;
  logic             bit_inc;

  assign rise = dht_s2 & ~dht_prev;
  assign fall = ~dht_s2 & dht_prev;

  assign timed_out = (state != IDLE) && (state != CHECK) && (cnt == TIMEOUT_C);

  // The cycle in which the rise is detected was already high but is not
  // counted (cnt clears on the transition), so add it back for the width.
  assign high_width = {1'b0, cnt} + 1'b1;
  assign bit_val    = (high_width > THRESH_C);

  assign sum = sr[39:32] + sr[31:24] + sr[23:16] + sr[15:8];

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    do_shift   = 1'b0;
    do_load    = 1'b0;
    do_cerr    = 1'b0;
    do_tout    = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    if (timed_out) begin
      state_next = IDLE;
      do_tout    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) state_next = WAIT_LOW;
        end
        WAIT_LOW: begin
          if (fall) state_next = RESP_LOW;
        end
        RESP_LOW: begin
          if (rise) state_next = RESP_HIGH;
        end
        RESP_HIGH: begin
          if (fall) begin
            state_next = BIT_LOW;
            bit_clr    = 1'b1;
          end
        end
        BIT_LOW: begin
          if (rise) state_next = BIT_HIGH;
        end
        BIT_HIGH: begin
          if (fall) begin
            do_shift = 1'b1;
            if (bit_idx == 6'd39) begin
              state_next = CHECK;
            end else begin
              state_next = BIT_LOW;
              bit_inc    = 1'b1;
            end
          end
        end
        CHECK: begin
          state_next = IDLE;
          if (sum == sr[7:0]) do_load = 1'b1;
          else                do_cerr = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + 1'b1;
    end
  end

  // Synchronizer resets to the idle-high line level so no edge appears after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dht_s1   <= 1'b1;
      dht_s2   <= 1'b1;
      dht_prev <= 1'b1;
    end else begin
      dht_s1   <= dht_in;
      dht_s2   <= dht_s1;
      dht_prev <= dht_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr      <= '0;
      bit_idx <= '0;
    end else begin
      if (do_shift) sr <= {sr[38:0], bit_val};
      if (bit_clr)      bit_idx <= '0;
      else if (bit_inc) bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hum_int      <= '0;
      hum_dec      <= '0;
      temp_int     <= '0;
      temp_dec     <= '0;
      data_valid   <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      data_valid   <= do_load;
      checksum_err <= do_cerr;
      timeout_err  <= do_tout;
      if (do_load) begin
        hum_int  <= sr[39:32];
        hum_dec  <= sr[31:24];
        temp_int <= sr[23:16];
        temp_dec <= sr[15:8];
      end
    end
  end

endmodule
